// File: rtl/prog_tick_timer_pkg.sv
// Shared types and constants for the programmable tick timer.
package prog_tick_timer_pkg;

  // Per-channel run state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } ch_state_t;

  // Channel mode encodings, as carried on cfg_oneshot.
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Width of the cfg_ch index. The extra bit lets out-of-range indices be expressed, and ignored.
  function automatic int CH_IDX_W(input int channels);
    return $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/tick_timer_ch.sv
// One timer channel: run FSM, counter, terminal-count/mode registers, tick and sticky done.
// Control inputs are single-cycle pulses sampled on each rising edge. There is no back-pressure.
// Priority within one edge: stop > start > terminal/count. A terminal event beats clr_done.
module tick_timer_ch
  import prog_tick_timer_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DEFAULT_TC = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_done,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_tc,
  input  logic             cfg_oneshot,
  output logic             tick,
  output logic             done,
  output ch_state_t        state
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] tc;
  logic             mode;

  // Channel FSM with registered tick/done. The config write lands at the same edge as the compare,
  // so the compare in that cycle still uses the old tc and mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      tc      <= WIDTH'(DEFAULT_TC);
      mode    <= MODE_PERIODIC;
    end else begin
      if (cfg_we) begin
        tc   <= cfg_tc;
        mode <= cfg_oneshot;
      end
      if (clr_done) begin
        done <= 1'b0;
      end
      tick <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        counter <= '0;
      end else if (start) begin
        state   <= ST_RUN;
        counter <= '0;
        done    <= 1'b0;
      end else if (state == ST_RUN && en) begin
        // ">=" rather than "==" so that a tc lowered below the live count fires at once
        // instead of wrapping through 2**WIDTH.
        if (counter >= tc) begin
          counter <= '0;
          tick    <= 1'b1;
          if (mode == MODE_ONESHOT) begin
            done  <= 1'b1;
            state <= ST_EXPIRED;
          end
        end else begin
          counter <= counter + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_tick_timer.sv
// Multi-channel programmable tick generator. It decodes configuration writes per channel
// and instantiates the independent channel timers.
module prog_tick_timer
  import prog_tick_timer_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int CHANNELS   = 2,
  parameter int DEFAULT_TC = 999
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             stop,
  input  logic [CHANNELS-1:0]             clr_done,
  input  logic                            cfg_we,
  input  logic [CH_IDX_W(CHANNELS)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                cfg_tc,
  input  logic                            cfg_oneshot,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS-1:0]             done
);

  localparam int IDX_W = CH_IDX_W(CHANNELS);

  // Per-channel FSM state. This is also the debug view of each channel.
  ch_state_t ch_state [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ch_we;

    // An index >= CHANNELS matches no channel, so the write is dropped.
    assign ch_we = cfg_we && (cfg_ch == IDX_W'(i));

    tick_timer_ch #(
      .WIDTH      (WIDTH),
      .DEFAULT_TC (DEFAULT_TC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .start       (start[i]),
      .stop        (stop[i]),
      .clr_done    (clr_done[i]),
      .cfg_we      (ch_we),
      .cfg_tc      (cfg_tc),
      .cfg_oneshot (cfg_oneshot),
      .tick        (tick[i]),
      .done        (done[i]),
      .state       (ch_state[i])
    );

    // busy is decoded from the registered state, so it carries no extra logic depth.
    assign busy[i] = (ch_state[i] == ST_RUN);
  end

endmodule
